// File: rtl/calendar_pkg.sv
// Shared calendar types, constants and the Gregorian leap-year rule.
package calendar_pkg;

    typedef logic [4:0] day_t;
    typedef logic [3:0] month_t;

    localparam day_t   DAY_MIN   = 5'd1;
    localparam month_t MONTH_FEB = 4'd2;
    localparam month_t MONTH_MAX = 4'd12;

    function automatic logic is_leap(input int unsigned year);
        return ((year % 4 == 0) && (year % 100 != 0)) || (year % 400 == 0);
    endfunction

endpackage

// File: rtl/day_counter_if.sv
// Signal bundle between the day counter and the rest of the calendar chain.
interface day_counter_if
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W = 14
);
    logic              en_1;
    logic              adjust;
    logic              up;
    logic              down;
    logic              carry_in;
    month_t            month_bin;
    logic [YEAR_W-1:0] year_bin;
    day_t              day_bin;
    day_t              days_in_month;
    logic              carry_out;

    modport master (
        output en_1, adjust, up, down, carry_in, month_bin, year_bin,
        input  day_bin, days_in_month, carry_out
    );

    modport slave (
        input  en_1, adjust, up, down, carry_in, month_bin, year_bin,
        output day_bin, days_in_month, carry_out
    );
endinterface

// File: rtl/day_counter_month_length.sv
// Combinational month length; illegal months report 31 days.
module month_length
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W = 14
) (
    input  month_t            month_bin,
    input  logic [YEAR_W-1:0] year_bin,
    output day_t              days_in_month
);

    // Map month (and year for February) to its number of days.
    always_comb begin
        days_in_month = 5'd31;
        if (month_bin == MONTH_FEB) begin
            days_in_month = is_leap(32'(year_bin)) ? 5'd29 : 5'd28;
        end else if (month_bin <= MONTH_MAX) begin
            case (month_bin)
                4'd4, 4'd6, 4'd9, 4'd11: days_in_month = 5'd30;
                default:                 days_in_month = 5'd31;
            endcase
        end
    end

endmodule

// File: rtl/day_counter.sv
// Day-of-month counter: counts on hour-counter carries, manual up/down adjust,
// clamps when the month shortens, and emits a carry to the month counter.
module day_counter
    import calendar_pkg::*;
#(
    parameter int unsigned YEAR_W      = 14,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic          clk_1Hz,
    input logic          rst,
    day_counter_if.slave bus
);

    logic [SYNC_STAGES-1:0] up_sync_q;
    logic [SYNC_STAGES-1:0] down_sync_q;
    logic                   up_prev_q;
    logic                   down_prev_q;
    logic                   up_pulse;
    logic                   down_pulse;
    logic                   count_step;
    day_t                   dim;
    day_t                   day_q, day_d;
    logic                   carry_q, carry_d;

    month_length #(
        .YEAR_W(YEAR_W)
    ) u_month_length (
        .month_bin    (bus.month_bin),
        .year_bin     (bus.year_bin),
        .days_in_month(dim)
    );

    // Synchronise the button levels, then keep one more stage for edge detection.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            up_sync_q   <= '0;
            down_sync_q <= '0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
        end else begin
            up_sync_q   <= {up_sync_q[SYNC_STAGES-2:0], bus.up};
            down_sync_q <= {down_sync_q[SYNC_STAGES-2:0], bus.down};
            up_prev_q   <= up_sync_q[SYNC_STAGES-1];
            down_prev_q <= down_sync_q[SYNC_STAGES-1];
        end
    end

    // Edges fire regardless of mode so a held button never steps on entering adjust.
    assign up_pulse   = up_sync_q[SYNC_STAGES-1] & ~up_prev_q;
    assign down_pulse = down_sync_q[SYNC_STAGES-1] & ~down_prev_q;
    assign count_step = ~bus.adjust & bus.en_1 & bus.carry_in;

    // Next day: count increment beats adjust step beats clamp.
    always_comb begin
        day_d   = day_q;
        carry_d = 1'b0;
        if (count_step) begin
            if (day_q >= dim) begin
                day_d   = DAY_MIN;
                carry_d = 1'b1;
            end else begin
                day_d = day_q + 5'd1;
            end
        end else if (bus.adjust && (up_pulse ^ down_pulse)) begin
            if (up_pulse) begin
                day_d = (day_q >= dim) ? DAY_MIN : day_q + 5'd1;
            end else begin
                day_d = (day_q <= DAY_MIN) ? dim : day_q - 5'd1;
            end
        end else if (day_q > dim) begin
            day_d = dim;
        end
    end

    // Day and carry registers.
    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            day_q   <= DAY_MIN;
            carry_q <= 1'b0;
        end else begin
            day_q   <= day_d;
            carry_q <= carry_d;
        end
    end

    assign bus.day_bin       = day_q;
    assign bus.carry_out     = carry_q;
    assign bus.days_in_month = dim;

endmodule

// File: tb/tb_day_counter.sv
// Directed self-checking bench for day_counter.
module tb_day_counter;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    day_counter_if #(.YEAR_W(14)) bus ();

    day_counter #(
        .YEAR_W     (14),
        .SYNC_STAGES(2)
    ) dut (
        .clk_1Hz(clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One carry_in pulse spanning exactly one rising edge; returns at a negedge.
    task automatic pulse_carry();
        @(negedge clk);
        bus.carry_in = 1'b1;
        @(negedge clk);
        bus.carry_in = 1'b0;
    endtask

    // Hold buttons long enough for one edge, release, and report any carry seen.
    task automatic press(input logic u, input logic d, output logic seen);
        seen = 1'b0;
        @(negedge clk);
        bus.up   = u;
        bus.down = d;
        repeat (5) begin
            @(negedge clk);
            seen |= bus.carry_out;
        end
        bus.up   = 1'b0;
        bus.down = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen |= bus.carry_out;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.day_bin !== 5'd1) begin
            errors++;
            $display("FAIL reset_day: got %0d expected 1", bus.day_bin);
        end
        checks++;
        if (bus.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_carry: got %0b expected 0", bus.carry_out);
        end
        checks++;
        if (bus.days_in_month !== 5'd30) begin
            errors++;
            $display("FAIL reset_dim_apr: got %0d expected 30", bus.days_in_month);
        end
        rst = 1'b0;
    endtask

    task automatic test_count_april();
        logic [4:0] exp_day;
        logic       exp_carry;
        bus.month_bin = 4'd4;
        bus.year_bin  = 14'd2024;
        for (int i = 1; i <= 30; i++) begin
            pulse_carry();
            exp_day   = (i == 30) ? 5'd1 : 5'(i + 1);
            exp_carry = (i == 30);
            checks++;
            if (bus.day_bin !== exp_day) begin
                errors++;
                $display("FAIL apr_day[%0d]: got %0d expected %0d", i, bus.day_bin, exp_day);
            end
            checks++;
            if (bus.carry_out !== exp_carry) begin
                errors++;
                $display("FAIL apr_carry[%0d]: got %0b expected %0b", i, bus.carry_out,
                         exp_carry);
            end
        end
    endtask

    task automatic test_feb_leap();
        int         years[4] = '{2024, 2100, 2000, 2023};
        logic [4:0] lens[4]  = '{5'd29, 5'd28, 5'd29, 5'd28};
        bus.month_bin = 4'd2;
        for (int k = 0; k < 4; k++) begin
            bus.year_bin = 14'(years[k]);
            #1;
            checks++;
            if (bus.days_in_month !== lens[k]) begin
                errors++;
                $display("FAIL feb_dim_%0d: got %0d expected %0d", years[k],
                         bus.days_in_month, lens[k]);
            end
            for (int i = 1; i < int'(lens[k]); i++) pulse_carry();
            checks++;
            if (bus.day_bin !== lens[k] || bus.carry_out !== 1'b0) begin
                errors++;
                $display("FAIL feb_last_%0d: got day %0d carry %0b expected day %0d carry 0",
                         years[k], bus.day_bin, bus.carry_out, lens[k]);
            end
            pulse_carry();
            checks++;
            if (bus.day_bin !== 5'd1 || bus.carry_out !== 1'b1) begin
                errors++;
                $display("FAIL feb_wrap_%0d: got day %0d carry %0b expected day 1 carry 1",
                         years[k], bus.day_bin, bus.carry_out);
            end
        end
    endtask

    task automatic test_adjust();
        logic seen;
        bus.month_bin = 4'd1;
        bus.year_bin  = 14'd2024;
        bus.adjust    = 1'b1;
        // Down from day 1: step lands on the third edge after the button is sampled.
        @(negedge clk);
        bus.down = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.day_bin !== 5'd1) begin
            errors++;
            $display("FAIL sync_early: got %0d expected 1", bus.day_bin);
        end
        @(negedge clk);
        checks++;
        if (bus.day_bin !== 5'd31) begin
            errors++;
            $display("FAIL adj_down_wrap: got %0d expected 31", bus.day_bin);
        end
        repeat (3) @(negedge clk);
        bus.down = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (bus.day_bin !== 5'd31 || bus.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL adj_down_hold: got day %0d carry %0b expected day 31 carry 0",
                     bus.day_bin, bus.carry_out);
        end
        press(1'b1, 1'b0, seen);
        checks++;
        if (bus.day_bin !== 5'd1 || seen !== 1'b0) begin
            errors++;
            $display("FAIL adj_up_wrap: got day %0d carry %0b expected day 1 carry 0",
                     bus.day_bin, seen);
        end
        press(1'b1, 1'b0, seen);
        checks++;
        if (bus.day_bin !== 5'd2) begin
            errors++;
            $display("FAIL adj_up: got %0d expected 2", bus.day_bin);
        end
        press(1'b1, 1'b1, seen);
        checks++;
        if (bus.day_bin !== 5'd2 || seen !== 1'b0) begin
            errors++;
            $display("FAIL adj_both: got day %0d carry %0b expected day 2 carry 0",
                     bus.day_bin, seen);
        end
        press(1'b0, 1'b1, seen);
        checks++;
        if (bus.day_bin !== 5'd1) begin
            errors++;
            $display("FAIL adj_down: got %0d expected 1", bus.day_bin);
        end
    endtask

    task automatic test_clamp();
        logic seen;
        press(1'b0, 1'b1, seen);  // day 1 -> 31 in January
        @(negedge clk);
        bus.adjust    = 1'b0;
        bus.month_bin = 4'd2;
        bus.year_bin  = 14'd2023;
        @(negedge clk);
        checks++;
        if (bus.day_bin !== 5'd28 || bus.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL clamp_feb: got day %0d carry %0b expected day 28 carry 0",
                     bus.day_bin, bus.carry_out);
        end
    endtask

    task automatic test_ignored();
        bus.adjust = 1'b1;
        pulse_carry();
        checks++;
        if (bus.day_bin !== 5'd28 || bus.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL ign_adjust: got day %0d carry %0b expected day 28 carry 0",
                     bus.day_bin, bus.carry_out);
        end
        bus.adjust = 1'b0;
        bus.en_1   = 1'b0;
        pulse_carry();
        checks++;
        if (bus.day_bin !== 5'd28 || bus.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL ign_en: got day %0d carry %0b expected day 28 carry 0",
                     bus.day_bin, bus.carry_out);
        end
        bus.en_1 = 1'b1;
        // Button held through the adjust 0->1 transition must not step.
        bus.up = 1'b1;
        repeat (5) @(negedge clk);
        bus.adjust = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (bus.day_bin !== 5'd28) begin
            errors++;
            $display("FAIL held_up: got %0d expected 28", bus.day_bin);
        end
        bus.up = 1'b0;
        repeat (4) @(negedge clk);
        bus.adjust = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.month_bin = 4'd1;
        bus.year_bin  = 14'd2024;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) pulse_carry();
        checks++;
        if (bus.day_bin !== 5'd17) begin
            errors++;
            $display("FAIL pre_reset: got %0d expected 17", bus.day_bin);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.day_bin !== 5'd1 || bus.carry_out !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got day %0d carry %0b expected day 1 carry 0",
                     bus.day_bin, bus.carry_out);
        end
        @(negedge clk);
        rst = 1'b0;
        pulse_carry();
        checks++;
        if (bus.day_bin !== 5'd2) begin
            errors++;
            $display("FAIL resume: got %0d expected 2", bus.day_bin);
        end
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        bus.en_1      = 1'b1;
        bus.adjust    = 1'b0;
        bus.up        = 1'b0;
        bus.down      = 1'b0;
        bus.carry_in  = 1'b0;
        bus.month_bin = 4'd4;
        bus.year_bin  = 14'd2024;
        test_reset();
        test_count_april();
        test_feb_leap();
        test_adjust();
        test_clamp();
        test_ignored();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/day_counter.md
Name: day_counter

Overview:
Day-of-month counter in the calendar chain, sitting between the hour counter and the month counter.
- Drives the carry pulse that the month counter consumes as its `carry_in`.
- Takes the current month and year back from the month/year counters to pick the month length, with Gregorian leap years for the millennium range.
- Supports manual up/down adjustment with synchronised, edge-detected buttons, in the same style as the other calendar fields.

Parameters:
- YEAR_W, 14, width of `year_bin` (covers years 0..9999).
- SYNC_STAGES, 2, flip-flop stages synchronising `up`/`down`; minimum 2.

Ports:
- clk_1Hz  input  1  single system clock; all state is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en_1  input  1  counting enable.
- adjust  input  1  0 = count mode, 1 = adjust mode.
- up  input  1  adjust-increment button, asynchronous level.
- down  input  1  adjust-decrement button, asynchronous level.
- carry_in  input  1  one-cycle day-rollover pulse from the hour counter.
- month_bin  input  4  current month, 1..12.
- year_bin  input  YEAR_W  current year, binary.
- day_bin  output  5  current day, 1..31.
- days_in_month  output  5  length of current month, combinational from `month_bin`/`year_bin`.
- carry_out  output  1  one-cycle pulse to the month counter's `carry_in`.

Behaviour:
- Reset (asynchronous, `rst`=1): `day_bin`=1, `carry_out`=0, all sync/edge flops cleared. Reset mid-adjust discards any pending edge.
- Month length:
  - 31 days: months 1, 3, 5, 7, 8, 10, 12.
  - 30 days: months 4, 6, 9, 11.
  - February: 29 if the year is a leap year, else 28. Leap year = (year%4==0 && year%100!=0) || year%400==0.
  - Illegal month (0 or 13..15): `days_in_month`=31.
- Count mode (`adjust`=0, `en_1`=1, `carry_in`=1):
  - If `day_bin` >= `days_in_month`: `day_bin`<=1 and `carry_out`<=1.
  - Else: `day_bin`<=`day_bin`+1 and `carry_out`<=0.
- `carry_out` in all other cycles: 0. It is registered and high for exactly one clk_1Hz cycle, aligned with `day_bin` becoming 1.
- `carry_in` while `adjust`=1 or `en_1`=0: ignored, and no carry is generated.
- Button synchronisation: `up` and `down` each pass through SYNC_STAGES flops, then one more flop for edge detection. A rising-edge pulse fires SYNC_STAGES+1 edges after the input first goes high. With SYNC_STAGES=2, `day_bin` updates on the 3rd clock edge after `up` is sampled high.
- Adjust mode (`adjust`=1), applied on an up/down edge pulse:
  - up: `day_bin` = (`day_bin` >= `days_in_month`) ? 1 : `day_bin`+1.
  - down: `day_bin` = (`day_bin` <= 1) ? `days_in_month` : `day_bin`-1.
  - Both pulses in the same cycle: no change.
  - Adjust never asserts `carry_out`.
- Edges while `adjust`=0: consumed (the edge detector keeps running) with no effect. Switching `adjust` 0->1 with a button already held does not produce a step.
- Clamp: in any cycle with no count or adjust action, if `day_bin` > `days_in_month` (month or year changed), `day_bin`<=`days_in_month`. Example: 31 Jan, month set to 2 in 2023 -> 28 on the next edge.
- Priority per cycle: reset > count increment > adjust step > clamp.
- `day_bin` never leaves 1..31 after reset.

Decomposition:
- Shared package `calendar_pkg`:
  - constants DAY_MIN=1, MONTH_FEB=2, MONTH_MAX=12;
  - 5-bit `day_t` and 4-bit `month_t` typedefs;
  - function `is_leap(year)`.
- One natural sub-module: `month_length`, a combinational map from (`month_bin`, `year_bin`) to `days_in_month`, reused later by a weekday calculator.
- Button sync/edge logic is instantiated twice inline; it is not a separate module.

Test Plan:
- Reset, then month=4, year=2024, 30 `carry_in` pulses -> `day_bin` counts 1..30 then wraps to 1; single `carry_out` pulse on the 30th pulse.
- Feb leap handling -> month=2: year=2024 wraps after 29; year=2100 after 28; year=2000 after 29; year=2023 after 28.
- Adjust mode, day=1, month=1, pulse `down` -> `day_bin`=31, no `carry_out`; pulse `up` -> 1; `up` and `down` simultaneous -> unchanged.
- Day=31, month=1, then `month_bin` changed to 2 with year=2023 -> `day_bin`=28 on the next edge; `carry_out` stays 0.
- `carry_in` pulses with `adjust`=1 or `en_1`=0 -> `day_bin` unchanged, `carry_out`=0; `up` held through an `adjust` 0->1 transition -> no step.
- Assert `rst` asynchronously mid-count at day=17 (between edges) -> `day_bin`=1 and `carry_out`=0 immediately; counting resumes from 1 after release.
